mem_arbiter: RTL

- Shares the single 128-bit main-memory port between the instruction cache (I side) and the data cache (D side) of the pipelined RISC-V core.
- Each cache keeps its existing level-held read/write request interface. The arbiter grants one requester at a time and registers the request onto the memory port.
- Returns mem_ready only to the granted requester and holds the returned line stable for that requester.
- Sits between the two cache instances and the memory model at the CHIP level.

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Purpose: shares one main-memory line port between the I-cache and the D-cache, one requester at a time.
// Latency: memory strobes appear the cycle after a request is seen in IDLE; the ready pulse follows mem_ready combinationally.
// Backpressure: requests are level-held until ready; one RELEASE cycle follows every transfer, and the losing side waits.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

    state_t state, state_nxt;
    logic   last_grant_d;   // 1 when the D side won the most recent grant
    logic   i_act, d_act;
    logic   grant_i, grant_d;

    assign i_act = i_read | i_write;
    assign d_act = d_read | d_write;

    // Ready goes only to the side that currently owns the memory port.
    assign i_ready = (state == GRANT_I) && mem_ready;
    assign d_ready = (state == GRANT_D) && mem_ready;
    assign busy    = (state != IDLE);

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: arbitration in IDLE, round-robin when both sides ask at once.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (i_act && d_act) begin
                    if (last_grant_d) grant_i = 1'b1;
                    else              grant_d = 1'b1;
                end else if (i_act) begin
                    grant_i = 1'b1;
                end else if (d_act) begin
                    grant_d = 1'b1;
                end
                if (grant_i)      state_nxt = GRANT_I;
                else if (grant_d) state_nxt = GRANT_D;
            end
            GRANT_I: if (mem_ready) state_nxt = RELEASE;
            GRANT_D: if (mem_ready) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-port and return-line registers: load on grant, clear strobes and capture read data on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_d <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            i_rdata      <= '0;
            d_rdata      <= '0;
        end else if (grant_i) begin
            // A write takes priority when a cache raises both strobes.
            mem_write    <= i_write;
            mem_read     <= i_read & ~i_write;
            mem_addr     <= i_addr;
            mem_wdata    <= i_wdata;
            last_grant_d <= 1'b0;
        end else if (grant_d) begin
            mem_write    <= d_write;
            mem_read     <= d_read & ~d_write;
            mem_addr     <= d_addr;
            mem_wdata    <= d_wdata;
            last_grant_d <= 1'b1;
        end else if (i_ready || d_ready) begin
            if (mem_read) begin
                if (i_ready) i_rdata <= mem_rdata;
                else         d_rdata <= mem_rdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

endmodule
